clap_detector: RTL



---
 rtl/clap_pkg.sv | 31 +++
 rtl/clap_debounce.sv | 58 +++++
 rtl/clap_detector.sv | 121 ++++++++++++
 3 files changed

// File: rtl/clap_pkg.sv
// clap_pkg: shared definitions for the clap detection path.
// Holds the 2-bit clap status encodings (also consumed by the display block),
// the default timing constants for a 100 MHz clock, the internal FSM state
// type and a helper that sizes the timing counters.
package clap_pkg;

  // Status encodings driven onto clap_state_o.
  localparam logic [1:0] CLAP_IDLE   = 2'b00;
  localparam logic [1:0] CLAP_ARMED  = 2'b01;
  localparam logic [1:0] CLAP_SINGLE = 2'b10;
  localparam logic [1:0] CLAP_DOUBLE = 2'b11;

  // Default timing at 100 MHz: 10 ms debounce, 500 ms window, 1 s hold.
  localparam int DEF_DEBOUNCE_CYC = 1000000;
  localparam int DEF_WINDOW_CYC   = 50000000;
  localparam int DEF_HOLD_CYC     = 100000000;

  // Classifier FSM states. REPORT covers both the single and double results;
  // which one is shown is carried by the registered status output.
  typedef enum logic [1:0] {
    FSM_IDLE   = 2'b00,
    FSM_ARMED  = 2'b01,
    FSM_REPORT = 2'b10
  } fsm_e;

  // Counter width for a counter that must reach n-1; never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clap_debounce.sv
// clap_debounce: two-flop synchroniser, stability-counter debouncer and
// rising-edge detector for the raw clap input.
//
// Ports:
//   clk_i   in  1  system clock
//   rst_i   in  1  asynchronous active-high reset
//   clap_i  in  1  raw asynchronous clap input
//   edge_o  out 1  one-cycle pulse on each accepted 0->1 of the debounced level
//
// The debounced level only changes after the synchronised level has disagreed
// with it for DEBOUNCE_CYC consecutive cycles; any return to agreement
// restarts the count, so shorter pulses never get through.
module clap_debounce
  import clap_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clap_i,
  output logic edge_o
);

  localparam int               CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      edge_o <= 1'b0;
    end else begin
      sync1  <= clap_i;
      sync2  <= sync1;
      edge_o <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level  <= sync2;
          cnt    <= '0;
          // Only an accepted rise produces an event; accepted falls are silent.
          edge_o <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clap_detector.sv
// clap_detector: classifies debounced claps as single or double and holds the
// result on the status output for a fixed display time.
//
// Ports:
//   clk_i         in  1   system clock
//   rst_i         in  1   asynchronous active-high reset
//   clap_i        in  1   raw asynchronous clap input, high = sound/press
//   clap_state_o  out 2   00 idle, 01 armed, 10 single, 11 double
//   single_o      out 1   one-cycle pulse when a single clap is classified
//   double_o      out 1   one-cycle pulse when a double clap is classified
//   clap_cnt_o    out 16  saturating count of accepted clap edges
//                         (present only when CLAP_COUNTER_EN is defined)
//
// Optional feature macro: CLAP_COUNTER_EN.
//
// clap_state_o doubles as the externally visible FSM state: 00 = IDLE,
// 01 = ARMED, 10/11 = REPORT. Pulses are registered together with the status
// change so a consumer sees both in the same cycle.
module clap_detector
  import clap_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int WINDOW_CYC   = DEF_WINDOW_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clap_i,
  output logic [1:0]  clap_state_o,
  output logic        single_o,
  output logic        double_o
`ifdef CLAP_COUNTER_EN
  ,
  output logic [15:0] clap_cnt_o
`endif
);

  localparam int            WW       = cnt_w(WINDOW_CYC);
  localparam int            HW       = cnt_w(HOLD_CYC);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYC - 1);
  localparam logic [HW-1:0] HLD_LAST = HW'(HOLD_CYC - 1);

  logic          clap_edge;
  fsm_e          state;
  logic [WW-1:0] win_cnt;
  logic [HW-1:0] hold_cnt;

  clap_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clap_i(clap_i),
    .edge_o(clap_edge)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= FSM_IDLE;
      clap_state_o <= CLAP_IDLE;
      single_o     <= 1'b0;
      double_o     <= 1'b0;
      win_cnt      <= '0;
      hold_cnt     <= '0;
    end else begin
      single_o <= 1'b0;
      double_o <= 1'b0;
      case (state)
        FSM_IDLE: begin
          if (clap_edge) begin
            state        <= FSM_ARMED;
            clap_state_o <= CLAP_ARMED;
            win_cnt      <= '0;
          end
        end
        FSM_ARMED: begin
          // Edge is tested first so a second clap on the expiry cycle still
          // classifies as a double.
          if (clap_edge) begin
            state        <= FSM_REPORT;
            clap_state_o <= CLAP_DOUBLE;
            double_o     <= 1'b1;
            hold_cnt     <= '0;
          end else if (win_cnt == WIN_LAST) begin
            state        <= FSM_REPORT;
            clap_state_o <= CLAP_SINGLE;
            single_o     <= 1'b1;
            hold_cnt     <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        FSM_REPORT: begin
          // Claps during the display time are locked out.
          if (hold_cnt == HLD_LAST) begin
            state        <= FSM_IDLE;
            clap_state_o <= CLAP_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state        <= FSM_IDLE;
          clap_state_o <= CLAP_IDLE;
        end
      endcase
    end
  end

`ifdef CLAP_COUNTER_EN
  // Counts every accepted rise, including those ignored while reporting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clap_cnt_o <= '0;
    end else if (clap_edge && (clap_cnt_o != 16'hFFFF)) begin
      clap_cnt_o <= clap_cnt_o + 16'd1;
    end
  end
`endif

endmodule
